// File: rtl/text_pkg.sv
// text_pkg: shared geometry, control codes and FSM states for the text buffer.
package text_pkg;
    localparam int COLS = 32;
    localparam int ROWS = 4;
    localparam int X0 = 192;
    localparam int Y0 = 208;
    localparam int CELL_W = 8;
    localparam int CELL_H = 16;
    localparam int CELLS = COLS * ROWS;
    localparam logic [7:0] BS = 8'h08;
    localparam logic [7:0] LF = 8'h0A;
    localparam logic [7:0] CR = 8'h0D;
    localparam logic [7:0] FF = 8'h0C;
    localparam logic [6:0] SPACE = 7'h20;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CLEAR = 2'd1;
    localparam logic [1:0] ST_SCROLL = 2'd2;
    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        CLEAR = ST_CLEAR,
        SCROLL = ST_SCROLL
    } state_e;
endpackage

// File: rtl/text_ram.sv
// text_ram: 128x7 cell store; port A comb read + sync write for the FSM,
// port B sync read for the display (returns the pre-write value on a collision).
module text_ram (
    input  logic       clk,
    input  logic       we,
    input  logic [6:0] wr_addr,
    input  logic [6:0] wr_data,
    input  logic [6:0] rd_addr_a,
    output logic [6:0] rd_data_a,
    input  logic [6:0] rd_addr_b,
    output logic [6:0] rd_data_b
);
    logic [6:0] mem [128];
    assign rd_data_a = mem[rd_addr_a];
    always_ff @(posedge clk) begin
        if (we) mem[wr_addr] <= wr_data;
        rd_data_b <= mem[rd_addr_b];
    end
endmodule

// File: rtl/text_buffer_ctrl.sv
// text_buffer_ctrl: character terminal buffer with clear/scroll FSM and a
// one-cycle pixel-to-character display lookup.
module text_buffer_ctrl #(
    parameter int COLS = text_pkg::COLS,
    parameter int ROWS = text_pkg::ROWS,
    parameter int X0 = text_pkg::X0,
    parameter int Y0 = text_pkg::Y0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready,
    input  logic [9:0] x,
    input  logic [9:0] y,
    output logic [6:0] ascii_code,
    output logic [4:0] cursor_col,
    output logic [1:0] cursor_row,
    output logic       busy
);
    import text_pkg::*;
    localparam logic [9:0] XL = 10'(X0);
    localparam logic [9:0] XH = 10'(X0 + COLS * CELL_W);
    localparam logic [9:0] YL = 10'(Y0);
    localparam logic [9:0] YH = 10'(Y0 + ROWS * CELL_H);
    state_e state;
    logic [6:0] cnt, cur, wr_addr, wr_data, rd_data_a, rd_addr_b, rd_data_b;
    logic we, accept, printable, in_win, win_q;
    assign rx_ready = state == IDLE;
    assign busy = state != IDLE;
    assign cursor_row = cur[6:5];
    assign cursor_col = cur[4:0];
    assign accept = rx_ready && rx_valid;
    assign printable = rx_data >= 8'h20 && rx_data <= 8'h7E;
    // Row-major linear index makes col/row wrap and backspace plain +/-1.
    always_comb begin
        we = 1'b0;
        wr_addr = cnt;
        wr_data = SPACE;
        if (state == CLEAR) we = 1'b1;
        else if (state == SCROLL) begin
            we = 1'b1;
            wr_data = cnt <= 7'd95 ? rd_data_a : SPACE;
        end else if (accept && printable) begin
            we = 1'b1;
            wr_addr = cur;
            wr_data = rx_data[6:0];
        end else if (accept && rx_data == BS && cur != 7'd0) begin
            we = 1'b1;
            wr_addr = cur - 7'd1;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CLEAR;
            cnt <= 7'd0;
            cur <= 7'd0;
            win_q <= 1'b0;
        end else begin
            win_q <= in_win;
            if (state != IDLE) begin
                cnt <= cnt == 7'd127 ? 7'd0 : cnt + 7'd1;
                if (cnt == 7'd127) state <= IDLE;
            end else if (accept) begin
                if (printable) begin
                    cur <= cur == 7'd127 ? 7'd96 : cur + 7'd1;
                    if (cur == 7'd127) state <= SCROLL;
                end else if (rx_data == LF || rx_data == CR) begin
                    cur <= {cur[6:5] == 2'd3 ? 2'd3 : cur[6:5] + 2'd1, 5'd0};
                    if (cur[6:5] == 2'd3) state <= SCROLL;
                end else if (rx_data == BS && cur != 7'd0) begin
                    cur <= cur - 7'd1;
                end else if (rx_data == FF) begin
                    cur <= 7'd0;
                    state <= CLEAR;
                end
            end
        end
    end
    assign in_win = x >= XL && x < XH && y >= YL && y < YH;
    assign rd_addr_b = {2'((y - YL) >> 4), 5'((x - XL) >> 3)};
    assign ascii_code = win_q ? rd_data_b : SPACE;
    text_ram u_ram (
        .clk(clk),
        .we(we),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .rd_addr_a(cnt + 7'd32),
        .rd_data_a(rd_data_a),
        .rd_addr_b(rd_addr_b),
        .rd_data_b(rd_data_b)
    );
endmodule

// File: doc/text_buffer_ctrl.md
TEXT_BUFFER_CTRL -- requirements
Module: text_buffer_ctrl

Interface
REQ-001 SHALL have parameter COLS, default 32, meaning characters per row.
REQ-002 SHALL have parameter ROWS, default 4, meaning text rows.
REQ-003 SHALL have parameter X0, default 192, meaning left pixel edge of the text window.
REQ-004 SHALL have parameter Y0, default 208, meaning top pixel edge of the text window (cells 8x16 px, so window x 192..447, y 208..271).
REQ-005 SHALL have port `clk`, input, 1 bit: the single clock.
REQ-006 SHALL have port `rst_n`, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have port `rx_data`, input, 8 bits: incoming character byte.
REQ-008 SHALL have port `rx_valid`, input, 1 bit: `rx_data` is valid.
REQ-009 SHALL have port `rx_ready`, output, 1 bit: the block accepts the byte this cycle.
REQ-010 SHALL have port `x`, input, 10 bits: current pixel column.
REQ-011 SHALL have port `y`, input, 10 bits: current pixel row.
REQ-012 SHALL have port `ascii_code`, output, 7 bits: character code for the font ROM.
REQ-013 SHALL have port `cursor_col`, output, 5 bits: current write column.
REQ-014 SHALL have port `cursor_row`, output, 2 bits: current write row.
REQ-015 SHALL have port `busy`, output, 1 bit: high when in CLEAR or SCROLL.

Function
REQ-016 SHALL store COLS*ROWS 7-bit cells; linear index = row*COLS+col.
REQ-017 SHALL implement an FSM with states IDLE, CLEAR and SCROLL; `rx_ready`=1 only in IDLE; a byte is accepted on a rising edge with `rx_valid`&&`rx_ready`.
REQ-018 SHALL, for an accepted printable byte (0x20-0x7E), write rx_data[6:0] at the cursor on the accept edge and advance the cursor: col+1; col 31 wraps to col 0 of row+1; from row 3 col 31 go to SCROLL with the cursor at row 3 col 0.
REQ-019 SHALL treat 0x0A and 0x0D as newline: col 0, row+1; on row 3 go to SCROLL with the cursor at row 3 col 0.
REQ-020 SHALL treat 0x08 as backspace: col>0 gives col-1; col 0 with row>0 gives row-1 col 31; in both cases write 0x20 at the new position; at row 0 col 0 the byte is a no-op.
REQ-021 SHALL treat 0x0C as form feed: go to CLEAR; cursor becomes 0,0.
REQ-022 SHALL consume every other byte (including bytes with bit 7 set) with no effect.
REQ-023 SHALL, in CLEAR, write 0x20 to one cell per cycle for indices 0..127, then return to IDLE (128 cycles).
REQ-024 SHALL, in SCROLL, for indices 0..95 copy cell[i+32] to cell[i], one per cycle, then write 0x20 to indices 96..127, then return to IDLE (128 cycles); the cursor is unchanged during SCROLL.
REQ-025 SHALL keep `busy` = (state != IDLE), equal to ~`rx_ready` outside reset.
REQ-026 SHALL run display lookup independently of the FSM: when (x,y) is inside the window, col=(x-X0)>>3 and row=(y-Y0)>>4; `ascii_code` is registered with exactly 1-cycle latency from x/y.
REQ-027 SHALL output `ascii_code`=0x20 when (x,y) is outside the window.
REQ-028 SHALL, during CLEAR and SCROLL, let display reads return the cell contents as of that cycle; no stalling of the display.
REQ-029 SHALL keep all index counters 7 bits wide, with explicit terminal compares at 127 and 95; no wrap beyond.

Reset
REQ-030 SHALL, while `rst_n`=0, hold state=CLEAR with counter 0, cursor 0,0, `rx_ready`=0, `busy`=1 and `ascii_code`=0x20.
REQ-031 SHALL, after release, run the full 128-cycle CLEAR, then enter IDLE.
REQ-032 SHALL, on reset assertion mid-CLEAR or mid-SCROLL, abort immediately and restart CLEAR from index 0 after release.

Structure
REQ-033 SHALL place in shared package text_pkg: COLS, ROWS, X0, Y0, cell dimensions, control-code constants (BS, LF, CR, FF, SPACE) and the state enum.
REQ-034 SHALL use one sub-module, text_ram: 128x7 dual-port memory; port A has combinational read plus synchronous write for the FSM; port B has synchronous read for display.

Verification
REQ-035 SHALL verify reset: after release `rx_ready`=0 for 128 cycles then 1; every in-window pixel yields `ascii_code`=0x20.
REQ-036 SHALL verify write: send 'H','I' -> cells 0,1 = 0x48,0x49; cursor 0,2; pixel (192,208) gives 0x48 one cycle later; pixel (200,220) gives 0x49.
REQ-037 SHALL verify wrap/scroll: send 128 printable bytes 'A'.. cycling -> the 128th write triggers SCROLL; `busy`=1 for 128 cycles; row 0 then holds the former row 1; row 3 is all 0x20; cursor 3,0.
REQ-038 SHALL verify backspace: at cursor 1,0 send 0x08 -> cursor 0,31 and cell 31 = 0x20; at 0,0 send 0x08 -> no change and byte consumed.
REQ-039 SHALL verify form feed and reset mid-op: send 0x0C -> CLEAR; assert `rst_n` at CLEAR index 60 -> outputs take reset values at once; after release, CLEAR restarts at 0 and takes 128 cycles.
REQ-040 SHALL verify backpressure: hold `rx_valid` with 'Z' during SCROLL -> not accepted until IDLE, then written exactly once.
